uart_echo_ctrl: RTL and testbench

UART_ECHO_CTRL -- requirements
Module: uart_echo_ctrl

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_echo_ctrl.sv | 121 ++++++++++++
 tb/tb_uart_echo_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART echo controller.
// Latency: n/a (declarations only).
// Backpressure: n/a. INJ_LF exists only when ECHO_CRLF_EN is defined.
package uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
`ifdef ECHO_CRLF_EN
    ,
    INJ_LF    = 3'd5
`endif
  } echo_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with occupancy count and first-word fall-through read.
// Latency: a push is visible on o_data/o_empty one clock after it is accepted.
// Backpressure: pushes are refused when full unless a pop happens in the same cycle.
//
// Ports:
//   i_clk, i_rstn   clock, async active-low reset
//   i_push, i_data  write request and data
//   i_pop           read request (ignored when empty)
//   o_data          head of queue
//   o_full, o_empty status flags
//   o_count         occupancy, 0..DEPTH
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the byte.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_echo_ctrl.sv
// UART echo controller: queues received bytes and replays them to the transmitter.
// Latency: byte strobed into an empty FIFO at cycle N gives o_tx_start at cycle N+3.
// Backpressure: waits on i_tx_busy per frame; bytes arriving into a full FIFO are dropped (sticky o_overflow).
//
// Ports:
//   i_clk, i_rstn          clock, async active-low reset
//   i_rx_data, i_rx_valid  received byte and one-cycle strobe
//   i_tx_busy              transmitter busy with a frame
//   o_tx_data, o_tx_start  byte to transmit and one-cycle start strobe
//   o_led                  last byte seen on i_rx_valid (dropped ones included)
//   o_overflow             sticky: a byte was dropped
//   o_count                FIFO occupancy
// Build option: define ECHO_CRLF_EN to follow every echoed CR with an injected LF.
module uart_echo_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic [DATA_W-1:0]           i_rx_data,
  input  logic                        i_rx_valid,
  input  logic                        i_tx_busy,
  output logic [DATA_W-1:0]           o_tx_data,
  output logic                        o_tx_start,
  output logic [DATA_W-1:0]           o_led,
  output logic                        o_overflow,
  output logic [$clog2(FIFO_DEPTH):0] o_count
);

  echo_state_t                r_state;
  logic [DATA_W-1:0]          r_tx_data;
  logic                       r_tx_start;
  logic [DATA_W-1:0]          r_led;
  logic                       r_overflow;

  logic [DATA_W-1:0]          w_fifo_data;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_pop;

  // LOAD is only entered with the FIFO non-empty and nothing else pops,
  // so the head byte is always valid here.
  assign w_pop = (r_state == LOAD);

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (i_rx_valid),
    .i_data  (i_rx_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_count)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= IDLE;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty && !i_tx_busy) r_state <= LOAD;
        end
        LOAD: begin
          r_tx_data  <= w_fifo_data;
          r_tx_start <= 1'b1;      // high exactly while in START
          r_state    <= START;
        end
        START: begin
          r_state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (i_tx_busy) r_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!i_tx_busy) begin
`ifdef ECHO_CRLF_EN
            r_state <= (r_tx_data == DATA_W'(ASCII_CR)) ? INJ_LF : IDLE;
`else
            r_state <= IDLE;
`endif
          end
        end
`ifdef ECHO_CRLF_EN
        INJ_LF: begin
          // LF is generated locally; the FIFO is left untouched.
          r_tx_data  <= DATA_W'(ASCII_LF);
          r_tx_start <= 1'b1;
          r_state    <= START;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_led      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (i_rx_valid) r_led <= i_rx_data;
      if (i_rx_valid && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_led      = r_led;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_uart_echo_ctrl.sv
module tb_uart_echo_ctrl;

  logic       i_clk;
  logic       i_rstn;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       i_tx_busy;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic [7:0] o_led;
  logic       o_overflow;
  logic [4:0] o_count;

  uart_echo_ctrl #(.FIFO_DEPTH(16), .DATA_W(8)) dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .i_tx_busy  (i_tx_busy),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .o_led      (o_led),
    .o_overflow (o_overflow),
    .o_count    (o_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       b;
    logic       es;
    logic [7:0] etd;
    logic [7:0] eled;
    logic [4:0] ecnt;
  } vec_t;

  vec_t       tbl[$];
  int         n_checks;
  int         n_fail;
  logic [7:0] got[$];
  int         n_start;
  int         busy_cnt;
  int         busy_len;
  logic       hold_busy;
  logic       start_seen;
  logic [4:0] max_cnt;
  int         cyc;
  int         first_start_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic b,
                     input logic es, input logic [7:0] etd, input logic [7:0] eled,
                     input logic [4:0] ecnt);
    vec_t e;
    e.v = v; e.d = d; e.b = b; e.es = es; e.etd = etd; e.eled = eled; e.ecnt = ecnt;
    tbl.push_back(e);
  endtask

  // One clock with a transmitter model: busy rises the cycle after a start
  // strobe and stays high busy_len cycles (or while hold_busy is set).
  task automatic tick();
    @(posedge i_clk); #1;
    cyc++;
    if (busy_cnt > 0) busy_cnt--;
    if (start_seen) busy_cnt = busy_len;
    start_seen = o_tx_start;
    if (o_tx_start) begin
      got.push_back(o_tx_data);
      n_start++;
      if (first_start_cyc < 0) first_start_cyc = cyc;
    end
    if (o_count > max_cnt) max_cnt = o_count;
    i_tx_busy = hold_busy || (busy_cnt > 0);
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    tick();
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
  endtask

  task automatic wait_starts(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (n_start < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, 32'(n_start >= n), 32'd1);
  endtask

  task automatic do_reset();
    i_rstn     = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    i_tx_busy  = 1'b0;
    hold_busy  = 1'b0;
    busy_cnt   = 0;
    start_seen = 1'b0;
    n_start    = 0;
    max_cnt    = '0;
    cyc        = 0;
    first_start_cyc = -1;
    got.delete();
    #7;
    chk("rst_tx_start", 32'(o_tx_start), 32'd0);
    chk("rst_tx_data",  32'(o_tx_data),  32'd0);
    chk("rst_led",      32'(o_led),      32'd0);
    chk("rst_overflow", 32'(o_overflow), 32'd0);
    chk("rst_count",    32'(o_count),    32'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;
  endtask

  initial begin
    int n0;
    logic [7:0] exp_seq[$];
    n_checks = 0;
    n_fail   = 0;
    busy_len = 4;

    //   v     d      b   | start  tx_data eled   count
    add(1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 8'h41, 5'd1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h41, 5'd1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 8'h41, 5'd0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 8'h41, 5'd0);
    add(1'b1, 8'h42, 1'b1, 1'b0, 8'h41, 8'h42, 5'd1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 8'h42, 5'd1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 8'h42, 5'd1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 8'h42, 5'd1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 8'h42, 8'h42, 5'd0);
    add(1'b1, 8'h43, 1'b0, 1'b0, 8'h42, 8'h43, 5'd1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 8'h42, 8'h43, 5'd1); // WAIT_ACK: no start despite data
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'h42, 8'h43, 5'd1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 8'h42, 8'h43, 5'd1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'h42, 8'h43, 5'd1); // IDLE held by busy
    add(1'b0, 8'h00, 1'b0, 1'b0, 8'h42, 8'h43, 5'd1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 8'h43, 8'h43, 5'd0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'h43, 8'h43, 5'd0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'h43, 8'h43, 5'd0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 8'h43, 8'h43, 5'd0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      i_rx_valid = tbl[i].v;
      i_rx_data  = tbl[i].d;
      i_tx_busy  = tbl[i].b;
      @(posedge i_clk); #1;
      chk($sformatf("vec%0d_start", i),   32'(o_tx_start), 32'(tbl[i].es));
      chk($sformatf("vec%0d_tx_data", i), 32'(o_tx_data),  32'(tbl[i].etd));
      chk($sformatf("vec%0d_led", i),     32'(o_led),      32'(tbl[i].eled));
      chk($sformatf("vec%0d_count", i),   32'(o_count),    32'(tbl[i].ecnt));
    end
    i_rx_valid = 1'b0;
    i_tx_busy  = 1'b0;
    chk("vec_overflow", 32'(o_overflow), 32'd0);

    // Single byte, 100-cycle frame: one start exactly at N+3.
    do_reset();
    busy_len = 100;
    n0 = cyc;
    send(8'h41);
    repeat (120) tick();
    chk("single_start_cycle", 32'(first_start_cyc), 32'(n0 + 3));
    chk("single_n_start", 32'(n_start), 32'd1);
    chk("single_tx_data", 32'(got.size() > 0 ? got[0] : 8'hxx), 32'h41);
    chk("single_led", 32'(o_led), 32'h41);

    // Burst of 16 bytes, 50-cycle frames: all delivered in order, no overflow.
    do_reset();
    busy_len = 50;
    for (int i = 1; i <= 16; i++) send(8'(i));
    wait_starts("burst_timeout", 16, 2000);
    repeat (60) tick();
    chk("burst_n_start", 32'(n_start), 32'd16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("burst_byte%0d", i), 32'(i < got.size() ? got[i] : 8'hxx), 32'(i + 1));
    chk("burst_overflow", 32'(o_overflow), 32'd0);
    chk("burst_peak", 32'(max_cnt == 5'd15 || max_cnt == 5'd16), 32'd1);

    // 18 bytes into a blocked transmitter: two dropped.
    do_reset();
    hold_busy = 1'b1;
    i_tx_busy = 1'b1;
    for (int i = 1; i <= 18; i++) send(8'(i));
    chk("ovf_count", 32'(o_count), 32'd16);
    chk("ovf_flag", 32'(o_overflow), 32'd1);
    chk("ovf_led", 32'(o_led), 32'h12);
    chk("ovf_no_start", 32'(n_start), 32'd0);
    hold_busy = 1'b0;
    i_tx_busy = 1'b0;
    busy_len  = 5;
    wait_starts("ovf_timeout", 16, 1000);
    repeat (100) tick();
    chk("ovf_n_start", 32'(n_start), 32'd16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("ovf_byte%0d", i), 32'(i < got.size() ? got[i] : 8'hxx), 32'(i + 1));
    chk("ovf_sticky", 32'(o_overflow), 32'd1);

    // Full FIFO with push and pop in the same cycle.
    do_reset();
    hold_busy = 1'b1;
    i_tx_busy = 1'b1;
    for (int i = 1; i <= 16; i++) send(8'(i));
    chk("full_count", 32'(o_count), 32'd16);
    hold_busy = 1'b0;
    i_tx_busy = 1'b0;
    busy_len  = 3;
    tick();                 // IDLE -> LOAD
    chk("full_load_count", 32'(o_count), 32'd16);
    send(8'h77);            // pop and push on the same edge
    chk("pushpop_count", 32'(o_count), 32'd16);
    chk("pushpop_overflow", 32'(o_overflow), 32'd0);
    wait_starts("pushpop_timeout", 17, 1500);
    chk("pushpop_byte15", 32'(got.size() > 15 ? got[15] : 8'hxx), 32'h10);
    chk("pushpop_byte16", 32'(got.size() > 16 ? got[16] : 8'hxx), 32'h77);

    // CR handling.
    do_reset();
    busy_len = 4;
    send(8'h0D);
    send(8'h61);
    repeat (200) tick();
`ifdef ECHO_CRLF_EN
    exp_seq = '{8'h0D, 8'h0A, 8'h61};
`else
    exp_seq = '{8'h0D, 8'h61};
`endif
    chk("crlf_n_start", 32'(n_start), 32'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size(); i++)
      chk($sformatf("crlf_byte%0d", i), 32'(i < got.size() ? got[i] : 8'hxx), 32'(exp_seq[i]));
    chk("crlf_led", 32'(o_led), 32'h61);

    // Reset during WAIT_DONE with 3 bytes queued.
    do_reset();
    busy_len = 1000;
    for (int i = 0; i < 4; i++) send(8'(8'h31 + i));
    repeat (10) tick();
    chk("midrst_pre_count", 32'(o_count), 32'd3);
    chk("midrst_pre_n_start", 32'(n_start), 32'd1);
    do_reset();
    repeat (50) tick();
    chk("midrst_n_start", 32'(n_start), 32'd0);
    chk("midrst_count", 32'(o_count), 32'd0);
    chk("midrst_tx_data", 32'(o_tx_data), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
